de_scoreboard: RTL and testbench
================================

DE_SCOREBOARD -- requirements
Module: de_scoreboard

Interface
REQ-001 Parameter: REGWORDS, 32, number of architectural registers.
REQ-002 Parameter: REGNOBITS, 5, register-index width.
REQ-003 Parameter: CNTBITS, 2, per-register pending-write counter width; saturation limit SB_MAX = 2^CNTBITS-1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, on the ports listed in REQ-005 and REQ-006.
REQ-005 Port: clk, input, 1, the only clock; all state updates on posedge clk.
REQ-006 Port: reset, input, 1, synchronous, active-high reset.
REQ-007 Port: valid_DE, input, 1, decode slot holds a valid instruction.
REQ-008 Port: rs1_DE / rs2_DE, input, REGNOBITS each, source register indices.
REQ-009 Port: use_rs1_DE / use_rs2_DE, input, 1 each, the source is actually read (R, I and S types per format).
REQ-010 Port: wr_DE, input, 1, instruction writes a destination register.
REQ-011 Port: rd_DE, input, REGNOBITS, destination register index.
REQ-012 Port: flush_DE, input, 1, branch-redirect kill of the decode-slot instruction.
REQ-013 Port: wr_reg_WB, input, 1, writeback of a register this cycle.
REQ-014 Port: wregno_WB, input, REGNOBITS, writeback register index.
REQ-015 Port: stall_DE, output, 1, hold FE and insert a bubble into the DE latch.
REQ-016 Port: issue_DE, output, 1, instruction is accepted into the DE latch this cycle.
REQ-017 Port: busy_vec, output, REGWORDS, bit i = pend[i] != 0 (registered state).
REQ-018 Port: err_underflow, output, 1, sticky flag for a retire with no pending write.
REQ-019 Port: stall_cycles, output, 32, performance counter of stalled cycles.

Function
REQ-020 Each register i SHALL own a counter pend[i]; pend[0] SHALL be held at 0.
REQ-021 Retire-hit: ret_hit[i] = wr_reg_WB & (wregno_WB == i) & (i != 0).
REQ-022 Effective pending: eff[i] = (pend[i] != 0) & !(pend[i] == 1 & ret_hit[i]), because the regfile writes on negedge, before the DE latch captures.
REQ-023 stall_DE SHALL be combinational and = valid_DE & !flush_DE & (raw_hazard | waw_full).
REQ-024 raw_hazard = (use_rs1_DE & rs1_DE != 0 & eff[rs1_DE]) | (use_rs2_DE & rs2_DE != 0 & eff[rs2_DE]).
REQ-025 waw_full = wr_DE & rd_DE != 0 & pend[rd_DE] == SB_MAX & !ret_hit[rd_DE].
REQ-026 issue_DE = valid_DE & !flush_DE & !stall_DE, combinational, same cycle.
REQ-027 On posedge, with inc = issue_DE & wr_DE & rd_DE != 0, for the targeted i:
  - inc only: pend += 1
  - retire only: pend -= 1
  - both on the same i: pend unchanged
REQ-028 A retire when pend[i] == 0 SHALL leave pend at 0 and set err_underflow, which stays set until reset.
REQ-029 pend SHALL never wrap; REQ-025 guarantees no increment beyond SB_MAX.
REQ-030 flush_DE SHALL suppress both issue and stall, and SHALL NOT alter any pend (in-flight instructions still retire).
REQ-031 stall_cycles SHALL increment by 1 on every posedge where stall_DE = 1, and wrap at 2^32.
REQ-032 Latency: hazard detect and issue are 0 cycles; busy_vec reflects an issue or retire 1 cycle later.

Reset
REQ-033 While reset = 1 at posedge, all pend SHALL be cleared to 0, err_underflow to 0 and stall_cycles to 0; busy_vec therefore reads 0.
REQ-034 Reset asserted mid-operation SHALL discard all pending state; any later retires of pre-reset instructions count as underflow.
REQ-035 During reset, stall_DE and issue_DE SHALL remain combinational from the inputs; the enclosing DE stage gates its latch by reset.

Structure
REQ-036 REGWORDS, REGNOBITS and SB_CNTBITS/SB_MAX SHALL live in the shared define.vh.
REQ-037 One sub-module, sb_counter, SHALL implement a saturating up/down counter with inc, dec and underflow outputs, instantiated REGWORDS-1 times (index 0 tied off).

Verification
REQ-038 Issue add x5 (wr=1, rd=5), next cycle valid instruction with rs1=5 -> stall_DE=1, busy_vec[5]=1; after wr_reg_WB=1, wregno_WB=5 in that cycle -> stall_DE=0 the same cycle, issue_DE=1.
REQ-039 Source rs2=0 with use_rs2=1 and pend irrelevant -> stall_DE=0; instruction with rd=0 issued -> busy_vec unchanged (all 0).
REQ-040 Issue three writes to x7 -> pend[7]=3; a fourth write to x7 -> stall_DE=1; same cycle retire x7 -> issue_DE=1 and pend[7] stays 3.
REQ-041 With x9 pending and flush_DE=1 on a reader of x9 -> stall_DE=0, issue_DE=0, pend[9] unchanged, stall_cycles not incremented.
REQ-042 Retire x12 with pend[12]=0 -> err_underflow=1 and pend[12]=0; err_underflow held until reset.
REQ-043 Stall 4 cycles, then assert reset for 1 cycle with busy_vec=0x00000A0 -> next cycle stall_cycles=0, busy_vec=0, err_underflow=0.

Source files
------------

// File: rtl/de_scoreboard_pkg.sv
// Shared sizing for the decode-stage register scoreboard.
package de_scoreboard_pkg;

    localparam int unsigned SB_REGWORDS  = 32;
    localparam int unsigned SB_REGNOBITS = 5;
    localparam int unsigned SB_CNTBITS   = 2;

    // Saturation limit of a pending-write counter of the given width.
    function automatic int unsigned sb_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned SB_MAX = sb_max(SB_CNTBITS);

endpackage

// File: rtl/de_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down, reports retire-at-zero.
module sb_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         underflow_c
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; neither direction wraps.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_c = dec && (cnt_q == '0);
        if (inc && !dec) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
        end else if (dec && !inc) begin
            if (cnt_q != '0) cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard: RAW/WAW stall, issue, pending-write tracking.
module de_scoreboard
    import de_scoreboard_pkg::*;
#(
    parameter int unsigned REGWORDS  = SB_REGWORDS,
    parameter int unsigned REGNOBITS = SB_REGNOBITS,
    parameter int unsigned CNTBITS   = SB_CNTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_DE,
    input  logic [REGNOBITS-1:0] rs1_DE,
    input  logic [REGNOBITS-1:0] rs2_DE,
    input  logic                 use_rs1_DE,
    input  logic                 use_rs2_DE,
    input  logic                 wr_DE,
    input  logic [REGNOBITS-1:0] rd_DE,
    input  logic                 flush_DE,
    input  logic                 wr_reg_WB,
    input  logic [REGNOBITS-1:0] wregno_WB,
    output logic                 stall_DE,
    output logic                 issue_DE,
    output logic [REGWORDS-1:0]  busy_vec,
    output logic                 err_underflow,
    output logic [31:0]          stall_cycles
);

    localparam int unsigned CNT_MAX = sb_max(CNTBITS);

    logic [REGWORDS-1:0][CNTBITS-1:0] pend;
    logic [REGWORDS-1:0]              ret_hit_c;
    logic [REGWORDS-1:0]              eff_c;
    logic [REGWORDS-1:1]              inc_c;
    logic [REGWORDS-1:1]              uflow_c;
    logic                             raw_hazard_c;
    logic                             waw_full_c;

    logic        err_underflow_q;
    logic        err_underflow_d;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // A retiring last write is visible to the reader this cycle (negedge regfile write).
    always_comb begin
        ret_hit_c = '0;
        eff_c     = '0;
        busy_vec  = '0;
        for (int i = 1; i < REGWORDS; i++) begin
            ret_hit_c[i] = wr_reg_WB && (wregno_WB == REGNOBITS'(i));
            eff_c[i]     = (pend[i] != '0) &&
                           !((pend[i] == CNTBITS'(1)) && ret_hit_c[i]);
            busy_vec[i]  = (pend[i] != '0);
        end
    end

    always_comb begin
        raw_hazard_c = (use_rs1_DE && (rs1_DE != '0) && eff_c[rs1_DE]) ||
                       (use_rs2_DE && (rs2_DE != '0) && eff_c[rs2_DE]);
        waw_full_c   = wr_DE && (rd_DE != '0) &&
                       (pend[rd_DE] == CNTBITS'(CNT_MAX)) && !ret_hit_c[rd_DE];
        stall_DE     = valid_DE && !flush_DE && (raw_hazard_c || waw_full_c);
        issue_DE     = valid_DE && !flush_DE && !stall_DE;
        inc_c        = '0;
        for (int i = 1; i < REGWORDS; i++) begin
            inc_c[i] = issue_DE && wr_DE && (rd_DE == REGNOBITS'(i));
        end
    end

    assign pend[0] = '0;

    for (genvar i = 1; i < REGWORDS; i++) begin : g_cnt
        sb_counter #(
            .W(CNTBITS)
        ) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .inc         (inc_c[i]),
            .dec         (ret_hit_c[i]),
            .cnt         (pend[i]),
            .underflow_c (uflow_c[i])
        );
    end

    always_comb begin
        err_underflow_d = err_underflow_q || (|uflow_c);
        stall_cycles_d  = stall_cycles_q + 32'(stall_DE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow_q <= 1'b0;
            stall_cycles_q  <= '0;
        end else begin
            err_underflow_q <= err_underflow_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign err_underflow = err_underflow_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Table-driven bench for de_scoreboard with a queue of expected registered results.
module tb_de_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_DE;
    logic [4:0]  rs1_DE;
    logic [4:0]  rs2_DE;
    logic        use_rs1_DE;
    logic        use_rs2_DE;
    logic        wr_DE;
    logic [4:0]  rd_DE;
    logic        flush_DE;
    logic        wr_reg_WB;
    logic [4:0]  wregno_WB;
    logic        stall_DE;
    logic        issue_DE;
    logic [31:0] busy_vec;
    logic        err_underflow;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    de_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .valid_DE      (valid_DE),
        .rs1_DE        (rs1_DE),
        .rs2_DE        (rs2_DE),
        .use_rs1_DE    (use_rs1_DE),
        .use_rs2_DE    (use_rs2_DE),
        .wr_DE         (wr_DE),
        .rd_DE         (rd_DE),
        .flush_DE      (flush_DE),
        .wr_reg_WB     (wr_reg_WB),
        .wregno_WB     (wregno_WB),
        .stall_DE      (stall_DE),
        .issue_DE      (issue_DE),
        .busy_vec      (busy_vec),
        .err_underflow (err_underflow),
        .stall_cycles  (stall_cycles)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic        use1;
        logic [4:0]  rs2;
        logic        use2;
        logic        wr;
        logic [4:0]  rd;
        logic        flush;
        logic        wb;
        logic [4:0]  wno;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] busy;
        logic        err;
        logic [31:0] sc;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] sc_model = 0;

    function automatic vec_t mk(input int valid, input int rs1, input int use1,
                                input int rs2, input int use2, input int wr,
                                input int rd, input int flush, input int wb,
                                input int wno, input int stall, input int issue,
                                input logic [31:0] busy, input int err);
        vec_t v;
        v.valid = 1'(valid); v.rs1 = 5'(rs1); v.use1 = 1'(use1);
        v.rs2 = 5'(rs2); v.use2 = 1'(use2); v.wr = 1'(wr); v.rd = 5'(rd);
        v.flush = 1'(flush); v.wb = 1'(wb); v.wno = 5'(wno);
        v.stall = 1'(stall); v.issue = 1'(issue); v.busy = busy; v.err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        valid_DE = v.valid; rs1_DE = v.rs1; use_rs1_DE = v.use1;
        rs2_DE = v.rs2; use_rs2_DE = v.use2; wr_DE = v.wr; rd_DE = v.rd;
        flush_DE = v.flush; wr_reg_WB = v.wb; wregno_WB = v.wno;
    endtask

    // Drive on negedge, check combinational outputs, then registered state after posedge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        drive(v);
        #1;
        chk({tag, ".stall"}, 32'(stall_DE), 32'(v.stall));
        chk({tag, ".issue"}, 32'(issue_DE), 32'(v.issue));
        sc_model = sc_model + 32'(v.stall);
        sbq.push_back('{busy: v.busy, err: v.err, sc: sc_model});
        @(posedge clk);
        #1;
        total++;
        if (sbq.size() == 0) begin
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            passed++;
            e = sbq.pop_front();
            chk({tag, ".busy"}, busy_vec, e.busy);
            chk({tag, ".err"}, 32'(err_underflow), 32'(e.err));
            chk({tag, ".stall_cycles"}, stall_cycles, e.sc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0);
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset.busy", busy_vec, 32'h0);
        chk("reset.err", 32'(err_underflow), 32'h0);
        chk("reset.stall_cycles", stall_cycles, 32'h0);

        vecs.push_back(idle);
        vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,32'h20,0));   // issue write x5
        vecs.push_back(mk(1,5,1,0,0,0,0,0,0,0, 1,0,32'h20,0));   // RAW on x5
        vecs.push_back(mk(1,5,1,0,0,0,0,0,1,5, 0,1,32'h0,0));    // same-cycle retire clears
        vecs.push_back(mk(1,0,0,0,1,1,0,0,0,0, 0,1,32'h0,0));    // rs2=x0, rd=x0
        vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 0,1,32'h80,0));
        vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 0,1,32'h80,0));
        vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 0,1,32'h80,0));   // pend[7]=3
        vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 1,0,32'h80,0));   // WAW full
        vecs.push_back(mk(1,0,0,0,0,1,7,0,1,7, 0,1,32'h80,0));   // retire frees slot, stays 3
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,32'h80,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,32'h80,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,32'h0,0));    // third retire empties x7
        vecs.push_back(mk(1,0,0,0,0,1,9,0,0,0, 0,1,32'h200,0));
        vecs.push_back(mk(1,9,1,0,0,0,0,1,0,0, 0,0,32'h200,0));  // flushed reader
        vecs.push_back(mk(1,0,0,0,0,1,11,1,0,0, 0,0,32'h200,0)); // flushed writer
        vecs.push_back(mk(1,9,1,0,0,0,0,0,0,0, 1,0,32'h200,0));  // x9 still pending
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,9, 0,0,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,12, 0,0,32'h0,1));   // underflow on x12
        vecs.push_back(idle_err());
        vecs.push_back(mk(1,0,0,0,0,1,3,0,0,0, 0,1,32'h8,1));
        vecs.push_back(mk(1,0,0,3,1,0,0,0,0,0, 1,0,32'h8,1));    // RAW via rs2
        vecs.push_back(mk(1,0,0,3,0,0,0,0,0,0, 0,1,32'h8,1));    // rs2 not read
        vecs.push_back(mk(1,3,1,0,0,0,0,0,1,3, 0,1,32'h0,1));
        vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,32'h20,1));
        vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 0,1,32'hA0,1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,5,1,0,0,0,0,0,0,0, 1,0,32'hA0,1)); // four stalled cycles

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        // Reset while a stalled reader is present: outputs stay combinational.
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1,5,1,0,0,0,0,0,0,0, 0,0,32'h0,0));
        #1;
        chk("rst.stall", 32'(stall_DE), 32'h1);
        chk("rst.issue", 32'(issue_DE), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(idle);
        sc_model = 0;
        chk("rst.busy", busy_vec, 32'h0);
        chk("rst.err", 32'(err_underflow), 32'h0);
        chk("rst.stall_cycles", stall_cycles, 32'h0);

        // Retire of an instruction issued before reset now underflows.
        step(mk(0,0,0,0,0,0,0,0,1,5, 0,0,32'h0,1), "post_rst_retire");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic vec_t idle_err();
        return mk(0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,1);
    endfunction

endmodule
